// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a classic 5-stage in-order pipeline.
// Tracks shadow copies of the EX/MEM/WB instructions, raises a one-cycle load-use
// stall, selects EX operand bypass sources, and counts stall and flush cycles.
module hazard_fwd_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0]       FwdRf  = 2'b00;
    localparam logic [1:0]       FwdWb  = 2'b01;
    localparam logic [1:0]       FwdMem = 2'b10;
    localparam logic [CNT_W-1:0] CntMax = '1;

    // EX stage record
    logic                  ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_reg_write_q, ex_reg_write_d;
    logic                  ex_mem_read_q, ex_mem_read_d;

    // MEM stage record
    logic                  mem_valid_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  mem_reg_write_q;

    // WB stage record
    logic                  wb_valid_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  wb_reg_write_q;

    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]      flush_count_q, flush_count_d;

    logic                  load_use;
    logic                  mem_src;
    logic                  wb_src;

    // Only real, register-writing instructions with a non-x0 target can bypass.
    assign mem_src = mem_valid_q & mem_reg_write_q & (mem_rd_q != '0);
    assign wb_src  = wb_valid_q & wb_reg_write_q & (wb_rd_q != '0);

    // Load in EX whose result the ID instruction needs; a taken branch kills ID anyway.
    always_comb begin
        load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) & id_valid &
                   ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                    (id_uses_rs2 & (id_rs2 == ex_rd_q)));
        stall    = load_use & ~ex_branch_taken;
    end

    // Operand A bypass select; MEM is newer than WB so it wins.
    always_comb begin
        forward_a = FwdRf;
        if (ex_valid_q) begin
            if (mem_src && (mem_rd_q == ex_rs1_q)) begin
                forward_a = FwdMem;
            end else if (wb_src && (wb_rd_q == ex_rs1_q)) begin
                forward_a = FwdWb;
            end
        end
    end

    // Operand B bypass select; same priority as operand A.
    always_comb begin
        forward_b = FwdRf;
        if (ex_valid_q) begin
            if (mem_src && (mem_rd_q == ex_rs2_q)) begin
                forward_b = FwdMem;
            end else if (wb_src && (wb_rd_q == ex_rs2_q)) begin
                forward_b = FwdWb;
            end
        end
    end

    // Next EX record: accept ID unless stalled or flushed, otherwise a bubble.
    always_comb begin
        ex_valid_d     = 1'b0;
        ex_rs1_d       = '0;
        ex_rs2_d       = '0;
        ex_rd_d        = '0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        if (!stall && !ex_branch_taken) begin
            ex_valid_d     = id_valid;
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
            ex_rd_d        = id_rd;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall && (stall_cycles_q != CntMax)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (ex_branch_taken && (flush_count_q != CntMax)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Pipeline shadow registers and counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            wb_valid_q      <= mem_valid_q;
            wb_rd_q         <= mem_rd_q;
            wb_reg_write_q  <= mem_reg_write_q;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios plus random traffic,
// compared each cycle against an instruction-level pipeline model.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic       ex_branch_taken;
    logic       stall;
    logic [1:0] forward_a, forward_b;
    logic [15:0] stall_cycles, flush_count;
    logic       stall_s;
    logic [1:0] forward_a_s, forward_b_s;
    logic [3:0] stall_cycles_s, flush_count_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .stall(stall),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow-counter copy so stall-counter saturation is reachable quickly.
    hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .stall(stall_s),
        .forward_a(forward_a_s), .forward_b(forward_b_s),
        .stall_cycles(stall_cycles_s), .flush_count(flush_count_s)
    );

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: the instructions that have left ID, newest first (EX, MEM, WB).
    typedef struct {
        bit v;
        int rs1, rs2, rd;
        bit rw, mr;
    } instr_t;

    instr_t inflight[3];
    int     m_stalls;
    int     m_flushes;

    // Sampled DUT outputs of the most recent step, for directed checks.
    int s_stall, s_fa, s_fb, s_sc, s_fc;

    function automatic void model_reset();
        instr_t nop;
        nop = '{v: 0, rs1: 0, rs2: 0, rd: 0, rw: 0, mr: 0};
        for (int k = 0; k < 3; k++) inflight[k] = nop;
        m_stalls  = 0;
        m_flushes = 0;
    endfunction

    // Newest older instruction that writes src supplies it; MEM=2, WB=1, none=0.
    function automatic int model_fwd(int src);
        if (!inflight[0].v) return 0;
        for (int k = 1; k < 3; k++) begin
            if (inflight[k].v && inflight[k].rw && inflight[k].rd != 0 && inflight[k].rd == src)
                return (k == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic int min_int(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit rw, input bit mr,
                        input bit br, input bit r);
        instr_t ex, idi;
        bit     exp_stall;
        @(negedge clk);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
        ex_branch_taken = br; rst = r;
        #1;
        ex = inflight[0];
        exp_stall = !br && ex.v && ex.mr && ex.rd != 0 && v &&
                    ((u1 && rs1 == ex.rd) || (u2 && rs2 == ex.rd));
        s_stall = int'(stall); s_fa = int'(forward_a); s_fb = int'(forward_b);
        s_sc = int'(stall_cycles); s_fc = int'(flush_count);
        check_val("stall", s_stall, exp_stall);
        check_val("fwd_a", s_fa, model_fwd(ex.rs1));
        check_val("fwd_b", s_fb, model_fwd(ex.rs2));
        check_val("stall_cycles", s_sc, m_stalls);
        check_val("flush_count", s_fc, m_flushes);
        check_val("stall_small", stall_s, exp_stall);
        check_val("stall_cycles_small", stall_cycles_s, min_int(m_stalls, 15));
        check_val("flush_count_small", flush_count_s, min_int(m_flushes, 15));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (exp_stall) m_stalls = min_int(m_stalls + 1, 65535);
            if (br) m_flushes = min_int(m_flushes + 1, 65535);
            idi = '{v: v, rs1: rs1, rs2: rs2, rd: rd, rw: rw, mr: mr};
            inflight[2] = inflight[1];
            inflight[1] = inflight[0];
            if (exp_stall || br) idi = '{v: 0, rs1: 0, rs2: 0, rd: 0, rw: 0, mr: 0};
            inflight[0] = idi;
        end
    endtask

    task automatic nop_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_reg_write = 0; id_mem_read = 0;
        ex_branch_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state
        nop_step();
        check_val("rst_stall", s_stall, 0);
        check_val("rst_fa", s_fa, 0);
        check_val("rst_sc", s_sc, 0);

        // ALU-ALU: consumer sees producer in MEM
        step(1, 0, 0, 5, 0, 0, 1, 0, 0, 0);
        step(1, 5, 0, 9, 1, 0, 1, 0, 0, 0);
        nop_step();
        check_val("alu_fa", s_fa, 2);
        check_val("alu_fb", s_fb, 0);
        check_val("alu_stall", s_stall, 0);

        // Distance 2: producer in WB
        reset_step();
        step(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 7, 2, 0, 1, 1, 0, 0, 0);
        nop_step();
        check_val("dist2_fb", s_fb, 1);

        // Load-use: one stall cycle, bubble, then WB forward
        reset_step();
        step(1, 0, 0, 6, 0, 0, 1, 1, 0, 0);
        step(1, 0, 6, 8, 0, 1, 1, 0, 0, 0);
        check_val("lu_stall", s_stall, 1);
        step(1, 0, 6, 8, 0, 1, 1, 0, 0, 0);
        check_val("lu_stall_clear", s_stall, 0);
        check_val("lu_bubble_fb", s_fb, 0);
        nop_step();
        check_val("lu_fb", s_fb, 1);
        check_val("lu_sc", s_sc, 1);

        // x0 never forwards; MEM beats WB on double match
        reset_step();
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        nop_step();
        check_val("x0_fa", s_fa, 0);
        step(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        step(1, 3, 0, 4, 1, 0, 1, 0, 0, 0);
        nop_step();
        check_val("dbl_fa", s_fa, 2);

        // Flush overrides load-use stall
        reset_step();
        step(1, 0, 0, 6, 0, 0, 1, 1, 0, 0);
        step(1, 0, 6, 8, 0, 1, 1, 0, 1, 0);
        check_val("fl_stall", s_stall, 0);
        nop_step();
        check_val("fl_fb", s_fb, 0);
        check_val("fl_fc", s_fc, 1);

        // Reset during a stall
        step(1, 0, 0, 6, 0, 0, 1, 1, 0, 0);
        step(1, 6, 0, 8, 1, 0, 1, 0, 0, 1);
        check_val("rs_stall_before", s_stall, 1);
        nop_step();
        check_val("rs_stall", s_stall, 0);
        check_val("rs_fa", s_fa, 0);
        check_val("rs_sc", s_sc, 0);
        check_val("rs_fc", s_fc, 0);

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        // Flush counter saturation
        reset_step();
        for (int i = 0; i < 65540; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1, 1, 1, 1, 1, 0);
        end
        nop_step();
        check_val("fc_sat", s_fc, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port id_valid, input, 1, ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd, input, REG_ADDR_W each, ID-stage register addresses.
REQ-007 SHALL have ports id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, input, 1 each, ID-stage decode flags.
REQ-008 SHALL have port ex_branch_taken, input, 1, EX-stage redirect; kills the ID instruction.
REQ-009 SHALL have port stall, output, 1, hold PC and IF/ID, insert bubble into EX.
REQ-010 SHALL have ports forward_a, forward_b, output, 2 each, select codes for the EX operand 3:1 muxes: 00 register file, 01 WB result, 10 MEM result.
REQ-011 SHALL have ports stall_cycles, flush_count, output, CNT_W each, performance counters.

Function
REQ-012 SHALL keep shadow stage records: EX {valid, rs1, rs2, rd, reg_write, mem_read}, MEM {valid, rd, reg_write}, WB {valid, rd, reg_write}.
REQ-013 Each cycle SHALL advance WB<=MEM, MEM<=EX.
REQ-014 EX record SHALL load from ID inputs when stall=0 and ex_branch_taken=0; otherwise EX SHALL become a bubble (valid=0, flags 0).
REQ-015 A stage SHALL be a forwarding source only if valid=1, reg_write=1, rd!=0.
REQ-016 forward_a SHALL be combinational: 10 if MEM source rd==EX rs1; else 01 if WB source rd==EX rs1; else 00; forward_b identical on EX rs2.
REQ-017 MEM SHALL take priority over WB when both match (newest value wins).
REQ-018 forward_a/forward_b SHALL be 00 when EX valid=0 and SHALL never be 11.
REQ-019 stall SHALL be combinational: 1 when EX valid, EX mem_read, EX rd!=0, id_valid, and (id_uses_rs1 and id_rs1==EX rd, or id_uses_rs2 and id_rs2==EX rd).
REQ-020 ex_branch_taken SHALL override: stall forced 0 in that cycle.
REQ-021 Load-use stall SHALL last exactly one cycle; the next cycle the load is in MEM, the stall condition clears, and the consumer later receives forward code 01 from WB.
REQ-022 stall_cycles SHALL increment by 1 per cycle with stall=1, saturating at all-ones.
REQ-023 flush_count SHALL increment by 1 per cycle with ex_branch_taken=1, saturating at all-ones.
REQ-024 Same-cycle WB-write/ID-read hazard SHALL be out of scope (handled by register file write-through).

Reset
REQ-025 When rst=1 at a clock edge, all stage valid bits and flags SHALL clear to 0, both counters to 0.
REQ-026 During and after reset, until a valid instruction reaches EX, stall SHALL be 0 and forward_a/forward_b SHALL be 00.
REQ-027 rst SHALL take priority over all other inputs, including mid-stall and mid-flush.

Verification
REQ-028 ALU-ALU: cycle0 ID add rd=5 rw=1; cycle1 ID sub rs1=5 uses_rs1=1 -> cycle2 forward_a=10, forward_b=00, stall=0.
REQ-029 Distance 2: producer rd=7, one unrelated instruction, consumer rs2=7 -> forward_b=01 when consumer in EX.
REQ-030 Load-use: ID lw rd=6 mem_read=1, next ID add rs2=6 -> stall=1 exactly one cycle, EX bubble, then forward_b=01; stall_cycles=1.
REQ-031 x0 and double-match: producer rd=0 -> code 00; MEM and WB both rd=3, EX rs1=3 -> forward_a=10.
REQ-032 Flush: ex_branch_taken=1 with load-use condition present -> stall=0, next EX bubble, flush_count+1; counters saturate at 16'hFFFF after 65535+ events.
REQ-033 Reset mid-stall: assert rst during stall=1 -> next cycle stall=0, forwards 00, both counters 0.
